// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types for the memory-port arbiter
package bus_pkg;

  localparam int BUS_ADDR_W = 64;
  localparam int BUS_DATA_W = 64;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_t;

  typedef struct packed {
    logic                    we;
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter for the single memory port, one transaction in flight
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int LSU_STREAK = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ifu_valid,
  input  logic [ADDR_W-1:0]   i_ifu_addr,
  output logic                o_ifu_ready,
  output logic                o_ifu_rvalid,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  input  logic                i_lsu_valid,
  input  logic                i_lsu_we,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wmask,
  output logic                o_lsu_ready,
  output logic                o_lsu_rvalid,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_mem_valid,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_ready,
  input  logic                i_mem_rsp_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int STREAK_W = (LSU_STREAK < 1) ? 1 : $clog2(LSU_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LSU_STREAK);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  mem_req_t              req_q, req_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  lsu_wins;
  logic                  rsp_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IFU;
      req_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
      streak_q <= streak_d;
    end
  end

  // LSU is the older instruction, but a waiting IFU is forced through after a full streak
  assign lsu_wins = i_lsu_valid && !(i_ifu_valid && (streak_q == STREAK_MAX));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_d        = req_q;
    streak_d     = streak_q;
    rsp_hit      = 1'b0;
    o_ifu_ready  = 1'b0;
    o_lsu_ready  = 1'b0;
    o_ifu_rvalid = 1'b0;
    o_ifu_rdata  = '0;
    o_lsu_rvalid = 1'b0;
    o_lsu_rdata  = '0;
    o_mem_valid  = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_wmask  = '0;

    case (state_q)
      ARB_IDLE: begin
        if (lsu_wins) begin
          o_lsu_ready = 1'b1;
          owner_d     = OWN_LSU;
          req_d.we    = i_lsu_we;
          req_d.addr  = i_lsu_addr;
          req_d.wdata = i_lsu_we ? i_lsu_wdata : '0;
          req_d.wmask = i_lsu_we ? i_lsu_wmask : '0;
          if (!i_ifu_valid)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
          state_d = ARB_REQ;
        end else if (i_ifu_valid) begin
          o_ifu_ready = 1'b1;
          owner_d     = OWN_IFU;
          req_d.we    = 1'b0;
          req_d.addr  = i_ifu_addr;
          req_d.wdata = '0;
          req_d.wmask = '0;
          streak_d    = '0;
          state_d     = ARB_REQ;
        end
      end
      ARB_REQ: begin
        o_mem_valid = 1'b1;
        o_mem_we    = req_q.we;
        o_mem_addr  = req_q.addr;
        o_mem_wdata = req_q.wdata;
        o_mem_wmask = req_q.wmask;
        if (i_mem_ready) begin
          if (i_mem_rsp_valid) begin
            rsp_hit = 1'b1;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        if (i_mem_rsp_valid) begin
          rsp_hit = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (rsp_hit) begin
      if (owner_q == OWN_LSU) begin
        o_lsu_rvalid = 1'b1;
        o_lsu_rdata  = req_q.we ? '0 : i_mem_rdata;
      end else begin
        o_ifu_rvalid = 1'b1;
        o_ifu_rdata  = i_mem_rdata;
      end
    end

    // Reset abandons any transaction in the same cycle, so nothing leaks out
    if (i_rst) begin
      o_ifu_ready  = 1'b0;
      o_lsu_ready  = 1'b0;
      o_ifu_rvalid = 1'b0;
      o_ifu_rdata  = '0;
      o_lsu_rvalid = 1'b0;
      o_lsu_rdata  = '0;
      o_mem_valid  = 1'b0;
      o_mem_we     = 1'b0;
      o_mem_addr   = '0;
      o_mem_wdata  = '0;
      o_mem_wmask  = '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int STREAK = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ifu_valid = 1'b0;
  logic [63:0] i_ifu_addr = '0;
  logic        o_ifu_ready, o_ifu_rvalid;
  logic [63:0] o_ifu_rdata;
  logic        i_lsu_valid = 1'b0, i_lsu_we = 1'b0;
  logic [63:0] i_lsu_addr = '0, i_lsu_wdata = '0;
  logic [7:0]  i_lsu_wmask = '0;
  logic        o_lsu_ready, o_lsu_rvalid;
  logic [63:0] o_lsu_rdata;
  logic        o_mem_valid, o_mem_we;
  logic [63:0] o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_ready = 1'b0, i_mem_rsp_valid = 1'b0;
  logic [63:0] i_mem_rdata = '0;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LSU_STREAK(STREAK)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ifu_valid(i_ifu_valid), .i_ifu_addr(i_ifu_addr), .o_ifu_ready(o_ifu_ready),
    .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rdata(o_ifu_rdata),
    .i_lsu_valid(i_lsu_valid), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_wmask(i_lsu_wmask), .o_lsu_ready(o_lsu_ready),
    .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
    .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_ready(i_mem_ready), .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rdata(i_mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // requester agents
  bit          ifu_pend = 0, lsu_pend = 0, lsu_st = 0;
  logic [63:0] ifu_a = '0, lsu_a = '0, lsu_d = '0;
  logic [7:0]  lsu_m = '0;
  int          ifu_rate = 0, lsu_rate = 0, store_rate = 0;
  // memory agent knobs
  int          wait_min = 0, wait_max = 0, rsp_min = 0, rsp_max = 0, stray_rate = 0;
  bit          fix_rdata_en = 0, force_rsp = 0;
  logic [63:0] fix_rdata = '0;
  // transaction-level reference model
  bit          txn_active = 0, txn_acc = 0, txn_lsu = 0, txn_we = 0;
  logic [63:0] txn_addr = '0, txn_wdata = '0;
  logic [7:0]  txn_wmask = '0;
  int          wait_left = 0, rsp_left = 0, streak = 0, cyc = 0;
  // observation logs
  logic        grant_log[$];
  int          ifu_grant_cyc = -1, ifu_rv_cyc = -1;
  logic [63:0] last_ifu_rdata = '0, last_lsu_rdata = '1, st_addr = '0, st_wdata = '0;
  logic [7:0]  st_wmask = '0;
  bit          st_we = 0, lsu_rv_seen = 0;

  task automatic start_txn(input bit is_lsu, input bit we, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] m);
    txn_active = 1; txn_acc = 0; txn_lsu = is_lsu; txn_we = we; txn_addr = a;
    txn_wdata = we ? d : 64'h0;
    txn_wmask = we ? m : 8'h0;
    wait_left = $urandom_range(wait_max, wait_min);
    rsp_left  = $urandom_range(rsp_max, rsp_min);
  endtask

  task automatic step(input bit rst);
    bit exp_mv, mr, rv, done, exp_ifu_rdy, exp_lsu_rdy, ifu_forced;
    logic [63:0] exp_rd;
    @(posedge i_clk);
    #1;
    cyc++;
    i_rst = rst;
    if (!ifu_pend && $urandom_range(99) < ifu_rate) begin
      ifu_pend = 1; ifu_a = {$urandom, $urandom} & ~64'h3;
    end
    if (!lsu_pend && $urandom_range(99) < lsu_rate) begin
      lsu_pend = 1; lsu_st = ($urandom_range(99) < store_rate);
      lsu_a = {$urandom, $urandom}; lsu_d = {$urandom, $urandom}; lsu_m = 8'($urandom);
    end
    i_ifu_valid = ifu_pend; i_ifu_addr = ifu_a;
    i_lsu_valid = lsu_pend; i_lsu_we = lsu_st; i_lsu_addr = lsu_a;
    i_lsu_wdata = lsu_d; i_lsu_wmask = lsu_m;

    exp_mv = txn_active && !txn_acc && !rst;
    mr = 0; rv = 0;
    if (exp_mv) begin
      if (wait_left == 0) begin
        mr = 1;
        if (rsp_left == 0) rv = 1;
      end else wait_left--;
    end else if (txn_active && !rst) begin
      rsp_left--;
      if (rsp_left == 0) rv = 1;
    end else if ($urandom_range(99) < stray_rate) rv = 1;
    if (force_rsp) rv = 1;
    i_mem_ready = mr; i_mem_rsp_valid = rv;
    i_mem_rdata = fix_rdata_en ? fix_rdata : {$urandom, $urandom};
    #2;

    exp_ifu_rdy = 0; exp_lsu_rdy = 0;
    if (!rst && !txn_active) begin
      ifu_forced = ifu_pend && (streak >= STREAK);
      if (lsu_pend && !ifu_forced) exp_lsu_rdy = 1;
      else if (ifu_pend) exp_ifu_rdy = 1;
    end
    done   = !rst && txn_active && rv && (txn_acc || mr);
    exp_rd = txn_we ? 64'h0 : i_mem_rdata;

    check("ready", {o_ifu_ready, o_lsu_ready}, {exp_ifu_rdy, exp_lsu_rdy});
    check("mem_valid", o_mem_valid, exp_mv);
    if (exp_mv) begin
      check("mem_we", o_mem_we, txn_we);
      check("mem_addr", o_mem_addr, txn_addr);
      check("mem_wdata", o_mem_wdata, txn_wdata);
      check("mem_wmask", o_mem_wmask, txn_wmask);
    end
    check("ifu_rvalid", o_ifu_rvalid, done && !txn_lsu);
    check("ifu_rdata", o_ifu_rdata, (done && !txn_lsu) ? i_mem_rdata : 64'h0);
    check("lsu_rvalid", o_lsu_rvalid, done && txn_lsu);
    check("lsu_rdata", o_lsu_rdata, (done && txn_lsu) ? exp_rd : 64'h0);
    if (rst)
      check("rst_outs", |{o_ifu_ready, o_ifu_rvalid, o_ifu_rdata, o_lsu_ready, o_lsu_rvalid,
                          o_lsu_rdata, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
                          o_mem_wmask}, 0);

    if (o_ifu_ready) begin grant_log.push_back(1'b0); ifu_grant_cyc = cyc; end
    if (o_lsu_ready) grant_log.push_back(1'b1);
    if (o_ifu_rvalid) begin ifu_rv_cyc = cyc; last_ifu_rdata = o_ifu_rdata; end
    if (o_lsu_rvalid) begin lsu_rv_seen = 1; last_lsu_rdata = o_lsu_rdata; end
    if (o_mem_valid && o_mem_we) begin
      st_we = 1; st_addr = o_mem_addr; st_wdata = o_mem_wdata; st_wmask = o_mem_wmask;
    end

    if (rst) begin
      txn_active = 0; streak = 0;
    end else begin
      if (done) txn_active = 0;
      else if (exp_mv && mr) txn_acc = 1;
      if (exp_lsu_rdy) begin
        streak = ifu_pend ? ((streak < STREAK) ? streak + 1 : streak) : 0;
        start_txn(1, lsu_st, lsu_a, lsu_d, lsu_m);
        lsu_pend = 0;
      end
      if (exp_ifu_rdy) begin
        streak = 0;
        start_txn(0, 0, ifu_a, 64'h0, 8'h0);
        ifu_pend = 0;
      end
    end
  endtask

  initial begin
    logic [9:0] pat;
    step(1); step(1);
    step(0);

    // IFU alone, zero-wait memory
    ifu_pend = 1; ifu_a = 64'h8000_0000; fix_rdata_en = 1; fix_rdata = 64'h13;
    repeat (4) step(0);
    check("t2_latency", 64'(ifu_rv_cyc - ifu_grant_cyc), 64'd1);
    check("t2_rdata", last_ifu_rdata, 64'h13);
    fix_rdata_en = 0;

    // tie: LSU first, IFU next
    grant_log.delete();
    ifu_pend = 1; ifu_a = 64'h8000_0040;
    lsu_pend = 1; lsu_st = 0; lsu_a = 64'h8000_0200;
    repeat (6) step(0);
    check("t3_grants", grant_log.size(), 2);
    pat = '0;
    for (int i = 0; i < grant_log.size() && i < 2; i++) pat = {pat[8:0], grant_log[i]};
    check("t3_order", pat, 10'b10);

    // store fields and zero completion data
    lsu_pend = 1; lsu_st = 1; lsu_a = 64'h8000_0100; lsu_d = 64'hAABB; lsu_m = 8'h03;
    lsu_rv_seen = 0; st_we = 0;
    repeat (4) step(0);
    check("t4_we", st_we, 1);
    check("t4_addr", st_addr, 64'h8000_0100);
    check("t4_wdata", st_wdata, 64'hAABB);
    check("t4_wmask", st_wmask, 8'h03);
    check("t4_rvalid", lsu_rv_seen, 1);
    check("t4_rdata", last_lsu_rdata, 64'h0);

    // streak: both always requesting
    grant_log.delete();
    ifu_rate = 100; lsu_rate = 100; store_rate = 50;
    repeat (30) step(0);
    ifu_rate = 0; lsu_rate = 0;
    pat = '0;
    for (int i = 0; i < 10; i++) pat = {pat[8:0], (i < grant_log.size()) ? grant_log[i] : 1'b0};
    check("t5_pattern", pat, 10'b1111011110);
    repeat (6) step(0);

    // memory stalls 5 cycles, then stray response while idle
    wait_min = 5; wait_max = 5;
    ifu_pend = 1; ifu_a = 64'h8000_1000;
    step(0);
    lsu_pend = 1; lsu_st = 0; lsu_a = 64'h8000_2000;
    grant_log.delete();
    repeat (6) step(0);
    check("t6_no_grant", grant_log.size(), 0);
    wait_min = 0; wait_max = 0;
    step(0);
    check("t6_after", grant_log.size(), 1);
    repeat (3) step(0);
    force_rsp = 1; step(0); force_rsp = 0;

    // reset while waiting for the response
    rsp_min = 3; rsp_max = 3;
    ifu_pend = 1; ifu_a = 64'h8000_3000;
    step(0); step(0); step(0);
    step(1);
    force_rsp = 1; step(0); force_rsp = 0;
    check("t1_idle", o_mem_valid, 0);
    rsp_min = 0; rsp_max = 0;
    repeat (2) step(0);

    // randomized traffic
    ifu_rate = 40; lsu_rate = 40; store_rate = 50;
    wait_min = 0; wait_max = 3; rsp_min = 0; rsp_max = 3; stray_rate = 10;
    repeat (3000) step($urandom_range(499) == 0);
    ifu_rate = 80; lsu_rate = 90; wait_max = 0; rsp_max = 0; stray_rate = 0;
    repeat (1000) step(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
